// File: rtl/rope_position_pkg.sv
// Shared Tug of War definitions: rope geometry, round states and score limit.
// Also used by the victory display stage.
package tow_pkg;

  localparam int NLED      = 7;
  localparam int CENTRE_IX = NLED / 2;
  localparam int SCORE_MAX = 9;

  localparam logic [NLED-1:0] CENTRE_ONEHOT = 7'b0001000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // True when exactly one bit of a rope position is set.
  function automatic logic pos_onehot(input logic [NLED-1:0] pos);
    return (pos != '0) && ((pos & (pos - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/rope_position_if.sv
// Player/game-control bundle between the button front end and rope_position.
// All signals are levels sampled on clk; there is no handshake, newgame is a one-cycle pulse.
interface rope_position_if #(
  parameter int NLED = 7
);
  logic            pbl;
  logic            pbr;
  logic            newgame;
  logic [NLED-1:0] pos_leds;
  logic            over;
  logic            winright;
  logic [3:0]      wins_l;
  logic [3:0]      wins_r;

  modport master (
    output pbl, pbr, newgame,
    input  pos_leds, over, winright, wins_l, wins_r
  );

  modport slave (
    input  pbl, pbr, newgame,
    output pos_leds, over, winright, wins_l, wins_r
  );
endinterface

// File: rtl/rope_position_edge_pulse.sv
// Registers a debounced button level and emits a one-cycle pulse on its rising edge.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic level_q_o,
  output logic pulse_o
);

  logic cur_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= level_i;
      prev_q <= cur_q;
    end
  end

  assign level_q_o = cur_q;
  assign pulse_o   = cur_q & ~prev_q;

endmodule

// File: rtl/rope_position.sv
// Tug of War game core: one-hot rope position, round winner and saturating win tallies.
module rope_position
  import tow_pkg::*;
#(
  parameter int NLED      = tow_pkg::NLED,
  parameter int SCORE_MAX = tow_pkg::SCORE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  rope_position_if.slave        bus,
  output state_e                state_o
);

  localparam logic [NLED-1:0] CENTRE = NLED'(1) << (NLED / 2);

  logic lvl_l, lvl_r;
  logic pls_l, pls_r;

  edge_pulse u_edge_l (
    .clk       (clk),
    .rst       (rst),
    .level_i   (bus.pbl),
    .level_q_o (lvl_l),
    .pulse_o   (pls_l)
  );

  edge_pulse u_edge_r (
    .clk       (clk),
    .rst       (rst),
    .level_i   (bus.pbr),
    .level_q_o (lvl_r),
    .pulse_o   (pls_r)
  );

  state_e          state_q;
  logic [NLED-1:0] pos_q;
  logic            over_q;
  logic            winright_q;
  logic [3:0]      wins_l_q, wins_r_q;

  logic            move_r, move_l, released;
  logic [3:0]      wins_l_d, wins_r_d;

  always_comb begin
    move_r   = pls_r & ~pls_l;
    move_l   = pls_l & ~pls_r;
    // Both buttons must be up, registered and incoming, so a held press never leaks into PLAY.
    released = ~lvl_l & ~lvl_r & ~bus.pbl & ~bus.pbr;
    wins_l_d = (wins_l_q < 4'(SCORE_MAX)) ? wins_l_q + 4'd1 : wins_l_q;
    wins_r_d = (wins_r_q < 4'(SCORE_MAX)) ? wins_r_q + 4'd1 : wins_r_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pos_q      <= CENTRE;
      over_q     <= 1'b0;
      winright_q <= 1'b0;
      wins_l_q   <= 4'd0;
      wins_r_q   <= 4'd0;
    end else if (bus.newgame) begin
      state_q    <= ST_IDLE;
      pos_q      <= CENTRE;
      over_q     <= 1'b0;
      winright_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pos_q <= CENTRE;
          if (released) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          if (!pos_onehot(pos_q)) begin
            pos_q <= CENTRE;
          end else if (move_r) begin
            pos_q <= pos_q >> 1;
            if (pos_q[1]) begin
              state_q    <= ST_OVER;
              over_q     <= 1'b1;
              winright_q <= 1'b1;
              wins_r_q   <= wins_r_d;
            end
          end else if (move_l) begin
            pos_q <= pos_q << 1;
            if (pos_q[NLED-2]) begin
              state_q    <= ST_OVER;
              over_q     <= 1'b1;
              winright_q <= 1'b0;
              wins_l_q   <= wins_l_d;
            end
          end
        end
        ST_OVER: begin
          if (!pos_onehot(pos_q)) pos_q <= CENTRE;
        end
        default: begin
          state_q <= ST_IDLE;
          pos_q   <= CENTRE;
        end
      endcase
    end
  end

  assign bus.pos_leds = pos_q;
  assign bus.over     = over_q;
  assign bus.winright = winright_q;
  assign bus.wins_l   = wins_l_q;
  assign bus.wins_r   = wins_r_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rope_position.sv
// Bench for rope_position: directed vector table, saturation sequence and random play vs a model.
module tb_rope_position;
  import tow_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rope_position_if #(.NLED(NLED)) bus();
  state_e dbg_state;

  rope_position #(.NLED(NLED), .SCORE_MAX(SCORE_MAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Rope kept as an integer index; presses derived from the history of sampled levels.
  int m_phase;          // 0 waiting for release, 1 playing, 2 round finished
  int m_idx;
  int m_over, m_wr, m_wl, m_wrs;
  bit h1_l, h2_l, h1_r, h2_r;

  function automatic int sat_inc(input int v);
    return (v < SCORE_MAX) ? v + 1 : v;
  endfunction

  task automatic model_edge(input bit r, input bit pl, input bit pr, input bit ng);
    bit press_l, press_r;
    press_l = h1_l & ~h2_l;
    press_r = h1_r & ~h2_r;
    if (r) begin
      m_phase = 0; m_idx = NLED / 2; m_over = 0; m_wr = 0; m_wl = 0; m_wrs = 0;
      h1_l = 0; h2_l = 0; h1_r = 0; h2_r = 0;
    end else begin
      if (ng) begin
        m_phase = 0; m_idx = NLED / 2; m_over = 0; m_wr = 0;
      end else if (m_phase == 0) begin
        m_idx = NLED / 2;
        if (!h1_l && !h1_r && !pl && !pr) m_phase = 1;
      end else if (m_phase == 1) begin
        if (press_r && !press_l) begin
          m_idx = m_idx - 1;
          if (m_idx == 0) begin m_phase = 2; m_over = 1; m_wr = 1; m_wrs = sat_inc(m_wrs); end
        end else if (press_l && !press_r) begin
          m_idx = m_idx + 1;
          if (m_idx == NLED - 1) begin m_phase = 2; m_over = 1; m_wr = 0; m_wl = sat_inc(m_wl); end
        end
      end
      h2_l = h1_l; h1_l = pl;
      h2_r = h1_r; h1_r = pr;
    end
  endtask

  task automatic check_model();
    chk("pos_leds", int'(bus.pos_leds), 1 << m_idx);
    chk("over", int'(bus.over), m_over);
    chk("winright", int'(bus.winright), m_wr);
    chk("wins_l", int'(bus.wins_l), m_wl);
    chk("wins_r", int'(bus.wins_r), m_wrs);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit pl, input bit pr, input bit ng, input bit do_check);
    rst = r; bus.pbl = pl; bus.pbr = pr; bus.newgame = ng;
    @(posedge clk);
    model_edge(r, pl, pr, ng);
    #1;
    if (do_check) check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         r, pl, pr, ng;
    logic [6:0] pos;
    bit         over, wr;
    int         wl, wrs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit r, pl, pr, ng, input logic [6:0] pos,
                              input bit over, wr, input int wl, wrs);
    vec_t v;
    v.r = r; v.pl = pl; v.pr = pr; v.ng = ng; v.pos = pos;
    v.over = over; v.wr = wr; v.wl = wl; v.wrs = wrs;
    return v;
  endfunction

  initial begin
    rst = 1'b1; bus.pbl = 1'b0; bus.pbr = 1'b0; bus.newgame = 1'b0;

    // reset with pbl held, then release before play begins
    vecs.push_back(mk(1, 1, 0, 0, 7'b0001000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 7'b0001000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 7'b0001000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 7'b0001000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0001000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0001000, 0, 0, 0, 0));
    // right win: press 1 cycle, release 3
    vecs.push_back(mk(0, 0, 1, 0, 7'b0001000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 7'b0000100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 7'b0000010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000001, 1, 1, 0, 1));
    // presses in OVER are ignored
    vecs.push_back(mk(0, 0, 1, 0, 7'b0000001, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0000001, 1, 1, 0, 1));
    // newgame coincident with a pbr pulse
    vecs.push_back(mk(0, 0, 1, 0, 7'b0000001, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 7'b0001000, 0, 0, 0, 1));
    // tie from centre
    vecs.push_back(mk(0, 0, 0, 0, 7'b0001000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 7'b0001000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0001000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0001000, 0, 0, 0, 1));
    // left win, then lockout
    vecs.push_back(mk(0, 1, 0, 0, 7'b0001000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0010000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 7'b0010000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 7'b0100000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 7'b0100000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 7'b1000000, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 7'b1000000, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 7'b1000000, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 7'b1000000, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 7'b1000000, 1, 0, 1, 1));

    foreach (vecs[i]) begin
      rst = vecs[i].r; bus.pbl = vecs[i].pl; bus.pbr = vecs[i].pr; bus.newgame = vecs[i].ng;
      @(posedge clk);
      model_edge(vecs[i].r, vecs[i].pl, vecs[i].pr, vecs[i].ng);
      #1;
      chk($sformatf("vec%0d_pos", i), int'(bus.pos_leds), int'(vecs[i].pos));
      chk($sformatf("vec%0d_over", i), int'(bus.over), int'(vecs[i].over));
      chk($sformatf("vec%0d_winright", i), int'(bus.winright), int'(vecs[i].wr));
      chk($sformatf("vec%0d_wins_l", i), int'(bus.wins_l), vecs[i].wl);
      chk($sformatf("vec%0d_wins_r", i), int'(bus.wins_r), vecs[i].wrs);
    end

    // ten more left wins: tally must stop at SCORE_MAX
    for (int r = 0; r < 10; r++) begin
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1);
      for (int p = 0; p < 3; p++) begin
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
      end
      chk("wins_l_sat", int'(bus.wins_l), (r + 2 > 9) ? 9 : r + 2);
    end
    chk("over_after_sat", int'(bus.over), 1);
    step(1, 0, 0, 0, 1);
    chk("wins_l_after_rst", int'(bus.wins_l), 0);
    chk("wins_r_after_rst", int'(bus.wins_r), 0);
    chk("pos_after_rst", int'(bus.pos_leds), 8);

    // randomized play against the model
    begin
      bit pl, pr;
      pl = 0; pr = 0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 2) == 0) pl = ~pl;
        if ($urandom_range(0, 2) == 0) pr = ~pr;
        step(($urandom_range(0, 699) == 0), pl, pr, ($urandom_range(0, 59) == 0), 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
